// File: rtl/controle_servo.sv
// Servo PWM: fixed-period pulse train whose high time is chosen by a 2-bit
// position command, latched only at period boundaries so pulses are never cut.
module controle_servo #(
  parameter int unsigned PERIODO    = 1_000_000,
  parameter int unsigned LARGURA_00 = 0,
  parameter int unsigned LARGURA_01 = 50_000,
  parameter int unsigned LARGURA_10 = 75_000,
  parameter int unsigned LARGURA_11 = 100_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] posicao,
  output logic       controle,
  output logic       db_controle
);

  localparam int unsigned   CW      = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIODO - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [31:0]   r_largura;
  logic [31:0]   w_largura_sel;
  logic [31:0]   w_largura_next;
  logic          w_wrap;
  logic          r_controle;

  always_comb begin
    w_largura_sel = '0;
    case (posicao)
      2'b00:   w_largura_sel = LARGURA_00;
      2'b01:   w_largura_sel = LARGURA_01;
      2'b10:   w_largura_sel = LARGURA_10;
      default: w_largura_sel = LARGURA_11;
    endcase

    w_wrap         = (r_cnt == CNT_MAX);
    w_cnt_next     = w_wrap ? '0 : r_cnt + CW'(1);
    w_largura_next = w_wrap ? w_largura_sel : r_largura;
  end

  // Compare in 32 bits so widths at or above PERIODO saturate to constant high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_largura  <= '0;
      r_controle <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_largura  <= w_largura_next;
      r_controle <= (32'(w_cnt_next) < w_largura_next);
    end
  end

  assign controle    = r_controle;
  assign db_controle = r_controle;

endmodule

// File: tb/tb_controle_servo.sv
// Bench for controle_servo: two small-period instances; expected high/low run
// lengths are queued with each command and matched by a waveform monitor.
module tb_controle_servo;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] posicao;
  logic       ctrl_a, db_a, ctrl_b, db_b;

  always #5 clk = ~clk;

  controle_servo #(
    .PERIODO(16), .LARGURA_00(0), .LARGURA_01(4), .LARGURA_10(9), .LARGURA_11(20)
  ) dut_a (
    .clock(clk), .reset(reset), .posicao(posicao),
    .controle(ctrl_a), .db_controle(db_a)
  );

  controle_servo #(
    .PERIODO(10), .LARGURA_00(0), .LARGURA_01(3), .LARGURA_10(10), .LARGURA_11(12)
  ) dut_b (
    .clock(clk), .reset(reset), .posicao(posicao),
    .controle(ctrl_b), .db_controle(db_b)
  );

  typedef struct {
    bit lvl;
    int len;
  } seg_t;

  seg_t exp_q[$];
  seg_t s;
  int   edge_k = 0;
  int   base   = 0;
  int   checks = 0;
  int   passed = 0;
  int   seg_no = 0;
  int   db_bad = 0;
  int   run    = 0;
  logic cur    = 1'b0;
  logic v;
  bit   first  = 1'b1;
  bit   mon_en = 1'b0;
  bit   sel    = 1'b0;
  bit   done   = 1'b0;
  bit   fin    = 1'b0;

  initial forever begin
    @(posedge clk);
    edge_k++;
  end

  task automatic push(input bit l, input int n);
    seg_t e;
    e.lvl = l;
    e.len = n;
    exp_q.push_back(e);
  endtask

  // Returns #1 after the edge numbered k relative to the last reset edge.
  task automatic go_to(input int k);
    while (edge_k - base < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: measures run lengths of the selected output at each falling edge.
  initial forever begin
    @(negedge clk);
    if (mon_en && !fin) begin
      v = sel ? ctrl_b : ctrl_a;
      if (first) begin
        first = 1'b0;
        checks++;
        if (ctrl_a === 1'b0 && db_a === 1'b0) passed++;
        else $display("FAIL reset_state: controle=%b db_controle=%b, required 0/0",
                      ctrl_a, db_a);
      end
      if (db_a !== ctrl_a || db_b !== ctrl_b) db_bad++;
      if (v === cur) begin
        run++;
      end else begin
        seg_no++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL seg%0d: level %b ran %0d cycles then changed, no segment required",
                   seg_no, cur, run);
        end else begin
          s = exp_q.pop_front();
          if (s.lvl === cur && s.len == run) passed++;
          else $display("FAIL seg%0d: got level %b for %0d cycles, required level %b for %0d cycles",
                        seg_no, cur, run, s.lvl, s.len);
        end
        cur = v;
        run = 1;
      end
      if (done) begin
        checks++;
        if (db_bad == 0) passed++;
        else $display("FAIL db_mirror: %0d cycles with db_controle != controle, required 0", db_bad);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL segments_left: %0d expected segments never seen, required 0",
                      exp_q.size());
        fin = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    posicao = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base  = edge_k;
    push(0, 48);
    mon_en = 1'b1;

    go_to(40);  posicao = 2'b01;
    push(1, 4); push(0, 12); push(1, 4); push(0, 12); push(1, 4); push(0, 12);
    go_to(90);  posicao = 2'b10;
    push(1, 9); push(0, 7); push(1, 9); push(0, 7);
    go_to(120); posicao = 2'b11;
    go_to(150); posicao = 2'b01;
    push(1, 36); push(0, 12); push(1, 4); push(0, 12);
    go_to(177); posicao = 2'b11;
    go_to(197); reset = 1'b1;
    push(1, 6); push(0, 16);
    go_to(198); reset = 1'b0; base = edge_k;

    go_to(20);  posicao = 2'b10;
    push(1, 25);
    go_to(42);  posicao = 2'b00;
    go_to(60);  posicao = 2'b01;
    push(0, 23); push(1, 4);
    go_to(70);  reset = 1'b1;
    push(0, 13); push(1, 3); push(0, 7);
    go_to(71);  reset = 1'b0; sel = 1'b1; base = edge_k;

    go_to(15);  posicao = 2'b10;
    push(1, 20);
    go_to(25);  posicao = 2'b11;
    go_to(35);  posicao = 2'b00;
    push(0, 10);
    go_to(45);  posicao = 2'b01;
    push(1, 3);
    go_to(56);
    done = 1'b1;

    wait (fin);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
